// File: rtl/alu_8_bit_pkg.sv
// ---------------------------------------------------------------------------
// alu_8_bit_pkg
//   Shared constants for the registered 8-bit ALU: operation encodings on the
//   2-bit select and the default datapath width.
//   Optional feature macro used by the block: ALU_FLAGS_EN (zero/overflow flags).
// ---------------------------------------------------------------------------
package alu_8_bit_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/alu_8_bit_core.sv
// ---------------------------------------------------------------------------
// alu_8_bit_core
//   Purely combinational ALU datapath: computes the next result and
//   carry/borrow (plus zero/overflow flags when ALU_FLAGS_EN is defined)
//   from the two unsigned operands and the operation select.
// Ports
//   i_a, i_b   operands (unsigned, WIDTH bits)
//   i_sel      operation: OP_ADD / OP_SUB / OP_AND / OP_OR
//   o_result   next result
//   o_carry    ADD carry-out, SUB borrow (A < B), 0 for logic ops
//   o_zero     [ALU_FLAGS_EN] next result == 0
//   o_ovf      [ALU_FLAGS_EN] signed overflow of ADD/SUB, 0 for logic ops
// Configuration macro: ALU_FLAGS_EN
// ---------------------------------------------------------------------------
module alu_8_bit_core
    import alu_8_bit_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_sel,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
`ifdef ALU_FLAGS_EN
    ,
    output logic             o_zero,
    output logic             o_ovf
`endif
);

    // Both arithmetic paths are one bit wider than the operands; the extra
    // MSB is the carry for ADD and the borrow for SUB (it is set exactly when
    // A < B because the zero-extended difference goes negative).
    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a variable unassigned, which would otherwise infer a latch.
        o_result = i_a | i_b;
        o_carry  = 1'b0;
        case (i_sel)
            OP_ADD:  {o_carry, o_result} = w_sum;
            OP_SUB:  {o_carry, o_result} = w_diff;
            OP_AND:  o_result = i_a & i_b;
            default: o_result = i_a | i_b;
        endcase
    end

`ifdef ALU_FLAGS_EN
    logic w_a_msb;
    logic w_b_msb;
    logic w_r_msb;

    assign w_a_msb = i_a[WIDTH-1];
    assign w_b_msb = i_b[WIDTH-1];
    assign w_r_msb = o_result[WIDTH-1];

    always_comb begin
        o_ovf = 1'b0;
        case (i_sel)
            // Same-sign operands producing a result of the other sign.
            OP_ADD:  o_ovf = (w_a_msb == w_b_msb) && (w_r_msb != w_a_msb);
            // Opposite-sign operands where the result loses A's sign.
            OP_SUB:  o_ovf = (w_a_msb != w_b_msb) && (w_r_msb != w_a_msb);
            default: o_ovf = 1'b0;
        endcase
    end

    assign o_zero = (o_result == '0);
`endif

endmodule

// File: rtl/alu_8_bit.sv
// ---------------------------------------------------------------------------
// alu_8_bit
//   Registered 8-bit ALU (ADD, SUB, AND, OR). Operands are sampled on a
//   rising edge with in_valid=1; result/carry_out appear one clock later
//   with out_valid=1. With in_valid=0 the data outputs hold and out_valid
//   drops. No back-pressure: one result per accepted cycle.
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   in_valid           accept A/B/sel on this edge
//   A, B               unsigned operands
//   sel                00 ADD, 01 SUB, 10 AND, 11 OR
//   result, carry_out  registered result and carry/borrow
//   out_valid          high for the cycle after an accepted operation
//   zero_flag, ovf_flag  [ALU_FLAGS_EN] registered zero / signed overflow
// Configuration macro: ALU_FLAGS_EN (adds the two flag ports and their logic)
// ---------------------------------------------------------------------------
module alu_8_bit
    import alu_8_bit_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             out_valid
`ifdef ALU_FLAGS_EN
    ,
    output logic             zero_flag,
    output logic             ovf_flag
`endif
);

    logic [WIDTH-1:0] w_next_result;
    logic             w_next_carry;

    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_valid;

`ifdef ALU_FLAGS_EN
    logic w_next_zero;
    logic w_next_ovf;
    logic r_zero;
    logic r_ovf;
`endif

    alu_8_bit_core #(
        .WIDTH    (WIDTH)
    ) u_core (
        .i_a      (A),
        .i_b      (B),
        .i_sel    (sel),
        .o_result (w_next_result),
        .o_carry  (w_next_carry)
`ifdef ALU_FLAGS_EN
        ,
        .o_zero   (w_next_zero),
        .o_ovf    (w_next_ovf)
`endif
    );

    // NOTE: the reset is in the sensitivity list so the outputs clear the
    // moment rst_n falls, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_valid  <= 1'b0;
`ifdef ALU_FLAGS_EN
            r_zero   <= 1'b1;   // consistent with the cleared result
            r_ovf    <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            r_valid <= in_valid;
            if (in_valid) begin
                r_result <= w_next_result;
                r_carry  <= w_next_carry;
`ifdef ALU_FLAGS_EN
                r_zero   <= w_next_zero;
                r_ovf    <= w_next_ovf;
`endif
            end
        end
    end

    assign result    = r_result;
    assign carry_out = r_carry;
    assign out_valid = r_valid;
`ifdef ALU_FLAGS_EN
    assign zero_flag = r_zero;
    assign ovf_flag  = r_ovf;
`endif

endmodule

// File: tb/tb_alu_8_bit.sv
// ---------------------------------------------------------------------------
// tb_alu_8_bit
//   Self-checking bench for alu_8_bit. Expected outputs are computed by an
//   integer reference model, pushed to a scoreboard queue when an operation
//   is driven and popped when the registered result is due.
//   Flag checks are compiled in when ALU_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_8_bit;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] res;
        logic         carry;
        logic         zero;
        logic         ovf;
    } exp_t;

    logic         clk      = 1'b0;
    logic         rst_n    = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a        = '0;
    logic [W-1:0] b        = '0;
    logic [1:0]   sel      = 2'b00;

    logic [W-1:0] result;
    logic         carry_out;
    logic         out_valid;
`ifdef ALU_FLAGS_EN
    logic         zero_flag;
    logic         ovf_flag;
`endif

    exp_t sb_q[$];
    exp_t exp_v;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_8_bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .sel       (sel),
        .result    (result),
        .carry_out (carry_out),
        .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
        ,
        .zero_flag (zero_flag),
        .ovf_flag  (ovf_flag)
`endif
    );

    always @(posedge clk) begin
        if (rst_n && in_valid)
            assert (!$isunknown(sel)) else $error("sel is unknown while in_valid is high");
    end

    // Reference model in plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [1:0] s);
        exp_t e;
        int ux = int'(x);
        int uy = int'(y);
        int sx = (ux >= 128) ? ux - 256 : ux;
        int sy = (uy >= 128) ? uy - 256 : uy;
        int r;
        e.carry = 1'b0;
        e.ovf   = 1'b0;
        e.res   = '0;
        case (s)
            2'b00: begin
                r       = ux + uy;
                e.res   = W'(r % 256);
                e.carry = (r > 255);
                e.ovf   = ((sx + sy) > 127) || ((sx + sy) < -128);
            end
            2'b01: begin
                r       = ux - uy;
                e.res   = W'((r + 256) % 256);
                e.carry = (ux < uy);
                e.ovf   = ((sx - sy) > 127) || ((sx - sy) < -128);
            end
            2'b10:   e.res = x & y;
            default: e.res = x | y;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] s);
        a        = x;
        b        = y;
        sel      = s;
        in_valid = 1'b1;
        sb_q.push_back(model(x, y, s));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, carry_out, result} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b carry=%b result=%0d exp 0/0/0",
                     out_valid, carry_out, result);
        end
`ifdef ALU_FLAGS_EN
        checks++;
        if ({zero_flag, ovf_flag} !== 2'b10) begin
            failures++;
            $display("FAIL reset_flags got zero=%b ovf=%b exp zero=1 ovf=0", zero_flag, ovf_flag);
        end
`endif
        step();
        @(negedge clk) rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_valid got %b exp 0", out_valid);
        end
    endtask

    // Runs a table of operations with one idle cycle between them.
    task automatic run_table(input string name, input logic [1:0] s,
                             input logic [W-1:0] xs[4], input logic [W-1:0] ys[4]);
        for (int i = 0; i < 4; i++) begin
            apply(xs[i], ys[i], s);
            step();
            in_valid = 1'b0;
            exp_v = sb_q.pop_front();
            checks++;
            if (out_valid !== 1'b1) begin
                failures++;
                $display("FAIL %s_valid[%0d] got %b exp 1", name, i, out_valid);
            end
            checks++;
            if ({carry_out, result} !== {exp_v.carry, exp_v.res}) begin
                failures++;
                $display("FAIL %s[%0d] A=%0d B=%0d got carry=%b result=%0d exp carry=%b result=%0d",
                         name, i, xs[i], ys[i], carry_out, result, exp_v.carry, exp_v.res);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if ({zero_flag, ovf_flag} !== {exp_v.zero, exp_v.ovf}) begin
                failures++;
                $display("FAIL %s_flags[%0d] got zero=%b ovf=%b exp zero=%b ovf=%b",
                         name, i, zero_flag, ovf_flag, exp_v.zero, exp_v.ovf);
            end
`endif
            step();
        end
    endtask

    task automatic test_add();
        logic [W-1:0] xs[4] = '{8'd10, 8'd255, 8'd200, 8'd100};
        logic [W-1:0] ys[4] = '{8'd5,  8'd1,   8'd100, 8'd28};
        run_table("add", 2'b00, xs, ys);
    endtask

    task automatic test_sub();
        logic [W-1:0] xs[4] = '{8'd20, 8'd0, 8'd128, 8'd77};
        logic [W-1:0] ys[4] = '{8'd4,  8'd1, 8'd1,   8'd77};
        run_table("sub", 2'b01, xs, ys);
    endtask

    task automatic test_logic();
        logic [W-1:0] xs[4] = '{8'b10101010, 8'h00, 8'hFF, 8'h0F};
        logic [W-1:0] ys[4] = '{8'b11110000, 8'hFF, 8'hFF, 8'hF0};
        run_table("and", 2'b10, xs, ys);
        run_table("or",  2'b11, xs, ys);
        // Spec vectors with literal expectations, independent of the model.
        apply(8'b10101010, 8'b11110000, 2'b10);
        step();
        apply(8'b10101010, 8'b11110000, 2'b11);
        checks++;
        if ({carry_out, result} !== {1'b0, 8'b10100000}) begin
            failures++;
            $display("FAIL and_literal got carry=%b result=%b exp 0/10100000", carry_out, result);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if ({carry_out, result} !== {1'b0, 8'b11111010}) begin
            failures++;
            $display("FAIL or_literal got carry=%b result=%b exp 0/11111010", carry_out, result);
        end
        sb_q.delete();
        step();
    endtask

    task automatic test_hold();
        apply(8'd200, 8'd100, 2'b00);
        step();
        exp_v = sb_q.pop_front();
        // Inputs change while idle; outputs must not follow them.
        in_valid = 1'b0;
        a        = 8'd1;
        b        = 8'd1;
        sel      = 2'b01;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL hold_valid[%0d] got %b exp 0", i, out_valid);
            end
            checks++;
            if ({carry_out, result} !== {exp_v.carry, exp_v.res}) begin
                failures++;
                $display("FAIL hold_data[%0d] got carry=%b result=%0d exp carry=%b result=%0d",
                         i, carry_out, result, exp_v.carry, exp_v.res);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            apply(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
                  2'($urandom_range(0, 3)));
            step();
            exp_v = sb_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || {carry_out, result} !== {exp_v.carry, exp_v.res}) begin
                failures++;
                $display("FAIL b2b[%0d] got valid=%b carry=%b result=%0d exp valid=1 carry=%b result=%0d",
                         i, out_valid, carry_out, result, exp_v.carry, exp_v.res);
            end
`ifdef ALU_FLAGS_EN
            checks++;
            if ({zero_flag, ovf_flag} !== {exp_v.zero, exp_v.ovf}) begin
                failures++;
                $display("FAIL b2b_flags[%0d] got zero=%b ovf=%b exp zero=%b ovf=%b",
                         i, zero_flag, ovf_flag, exp_v.zero, exp_v.ovf);
            end
`endif
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        apply(8'd10, 8'd5, 2'b00);
        step();
        exp_v = sb_q.pop_front();
        checks++;
        if (result !== exp_v.res) begin
            failures++;
            $display("FAIL pre_reset got result=%0d exp %0d", result, exp_v.res);
        end
        // An op is pending on the inputs but reset falls before its edge.
        a = 8'd255; b = 8'd3; sel = 2'b00; in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, carry_out, result} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL mid_reset_async got valid=%b carry=%b result=%0d exp 0/0/0",
                     out_valid, carry_out, result);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, result} !== {1'b0, 8'h00}) begin
            failures++;
            $display("FAIL mid_reset_held got valid=%b result=%0d exp 0/0", out_valid, result);
        end
        in_valid = 1'b0;
        #3 rst_n = 1'b1;
        step();
        checks++;
        if ({out_valid, carry_out, result} !== {1'b0, 1'b0, 8'h00}) begin
            failures++;
            $display("FAIL post_reset_stale got valid=%b carry=%b result=%0d exp 0/0/0",
                     out_valid, carry_out, result);
        end
        apply(8'd20, 8'd4, 2'b01);
        step();
        in_valid = 1'b0;
        exp_v = sb_q.pop_front();
        checks++;
        if ({out_valid, carry_out, result} !== {1'b1, exp_v.carry, exp_v.res}) begin
            failures++;
            $display("FAIL post_reset_op got valid=%b carry=%b result=%0d exp 1/%b/%0d",
                     out_valid, carry_out, result, exp_v.carry, exp_v.res);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
